// File: rtl/writeback_regfile_if.sv
// Memory-stage to write-back bus: the retiring instruction payload plus the ready handshake.
interface writeback_regfile_if;
    logic [31:0] IR_in;
    logic [31:0] RD_in;
    logic [31:0] A_in;
    logic [31:0] PC_in;
    logic [4:0]  AM_in;
    logic        v_in;
    logic        r_out;

    modport master (output IR_in, RD_in, A_in, PC_in, AM_in, v_in, input r_out);
    modport slave  (input IR_in, RD_in, A_in, PC_in, AM_in, v_in, output r_out);
endinterface

// File: rtl/writeback_regfile.sv
// Write-back stage: builds the architectural result, writes the 32x32 register file,
// serves two decode read ports, a forwarding tap for execute and a retired-instruction count.
module writeback_regfile #(
    parameter int unsigned CNT_W  = 64,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_regfile_if.slave   mem,
    input  logic                 stall,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [31:0]          rs1_data,
    output logic [31:0]          rs2_data,
    output logic [4:0]           fwd_rd,
    output logic [31:0]          fwd_data,
    output logic                 fwd_v,
    output logic                 retire_v,
    output logic [CNT_W-1:0]     instret
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 32;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic [XLEN-1:0] regs [NREGS];
    logic            r_out_q;

    logic [6:0]      opcode_c;
    logic [2:0]      funct3_c;
    logic            accept_c;
    logic            sel_c;
    logic            we_c;
    logic [XLEN-1:0] wb_value_c;
    logic            unused_ir_c;

    assign opcode_c    = mem.IR_in[6:0];
    assign funct3_c    = mem.IR_in[14:12];
    assign accept_c    = mem.v_in & r_out_q & ~rst;
    assign unused_ir_c = ^{mem.IR_in[31:15], mem.IR_in[11:7]};
    assign mem.r_out   = r_out_q;

    // Result select; RD_in only feeds the value on a load, so a floating bus cannot leak in.
    always_comb begin
        sel_c      = 1'b0;
        wb_value_c = '0;
        case (opcode_c)
            OP_LOAD: begin
                case (funct3_c)
                    3'd0: begin
                        sel_c      = 1'b1;
                        wb_value_c = {{24{mem.RD_in[7]}}, mem.RD_in[7:0]};
                    end
                    3'd4: begin
                        sel_c      = 1'b1;
                        wb_value_c = {24'h0, mem.RD_in[7:0]};
                    end
                    3'd1: begin
                        sel_c      = 1'b1;
                        wb_value_c = {{16{mem.RD_in[15]}}, mem.RD_in[15:0]};
                    end
                    3'd5: begin
                        sel_c      = 1'b1;
                        wb_value_c = {16'h0, mem.RD_in[15:0]};
                    end
                    3'd2: begin
                        sel_c      = 1'b1;
                        wb_value_c = mem.RD_in;
                    end
                    default: ;
                endcase
            end
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC: begin
                sel_c      = 1'b1;
                wb_value_c = mem.A_in;
            end
            OP_JAL, OP_JALR: begin
                sel_c      = 1'b1;
                wb_value_c = mem.PC_in + XLEN'(4);
            end
            default: ;
        endcase
    end

    assign we_c = accept_c & sel_c & (mem.AM_in != '0);

    // Read port 1: x0 hardwired, optional write-through of the in-flight result.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            if (BYPASS && we_c && (mem.AM_in == rs1_addr)) begin
                rs1_data = wb_value_c;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            if (BYPASS && we_c && (mem.AM_in == rs2_addr)) begin
                rs2_data = wb_value_c;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

    // Register file, handshake, forwarding tap and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[AW'(i)] <= '0;
            end
            r_out_q  <= 1'b1;
            fwd_v    <= 1'b0;
            fwd_rd   <= '0;
            fwd_data <= '0;
            retire_v <= 1'b0;
            instret  <= '0;
        end else begin
            r_out_q  <= ~stall;
            retire_v <= accept_c;
            fwd_v    <= we_c;
            if (accept_c) begin
                instret <= instret + CNT_W'(1);
            end
            if (we_c) begin
                regs[mem.AM_in] <= wb_value_c;
                fwd_rd          <= mem.AM_in;
                fwd_data        <= wb_value_c;
            end
        end
    end
endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios plus a randomized run,
// checked against a behavioural model; a write-through and a no-bypass instance run side by side.
module tb_writeback_regfile;
    localparam int unsigned CNT_W = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data_b, rs2_data_b, rs1_data_n, rs2_data_n;
    logic [4:0]  fwd_rd, fwd_rd_n;
    logic [31:0] fwd_data, fwd_data_n;
    logic        fwd_v, fwd_v_n, retire_v, retire_v_n;
    logic [CNT_W-1:0] instret, instret_n;

    int checks = 0;
    int failures = 0;

    writeback_regfile_if bus_b ();
    writeback_regfile_if bus_n ();

    assign bus_n.IR_in = bus_b.IR_in;
    assign bus_n.RD_in = bus_b.RD_in;
    assign bus_n.A_in  = bus_b.A_in;
    assign bus_n.PC_in = bus_b.PC_in;
    assign bus_n.AM_in = bus_b.AM_in;
    assign bus_n.v_in  = bus_b.v_in;

    writeback_regfile #(.CNT_W(CNT_W), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .mem(bus_b.slave), .stall(stall),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_v(fwd_v),
        .retire_v(retire_v), .instret(instret)
    );

    writeback_regfile #(.CNT_W(CNT_W), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst(rst), .mem(bus_n.slave), .stall(stall),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_n), .rs2_data(rs2_data_n),
        .fwd_rd(fwd_rd_n), .fwd_data(fwd_data_n), .fwd_v(fwd_v_n),
        .retire_v(retire_v_n), .instret(instret_n)
    );

    always #5 clk = ~clk;

    // Behavioural reference model
    logic [31:0]      m_regs [32];
    logic [CNT_W-1:0] m_instret;
    logic             m_rout, m_fwd_v, m_retire;
    logic [4:0]       m_fwd_rd;
    logic [31:0]      m_fwd_data;

    function automatic void m_decode(input logic [31:0] ir, input logic [31:0] rd,
                                     input logic [31:0] a, input logic [31:0] pc,
                                     output bit writes, output logic [31:0] val);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[7:0];
        h = rd[15:0];
        writes = 1'b1;
        val = 32'h0;
        case (ir[6:0])
            7'h03: begin
                case (ir[14:12])
                    3'd0: val = 32'($signed(b));
                    3'd4: val = 32'(b);
                    3'd1: val = 32'($signed(h));
                    3'd5: val = 32'(h);
                    3'd2: val = rd;
                    default: writes = 1'b0;
                endcase
            end
            7'h33, 7'h13, 7'h37, 7'h17: val = a;
            7'h6F, 7'h67: val = pc + 32'd4;
            default: writes = 1'b0;
        endcase
    endfunction

    function automatic void m_pending(output bit we, output logic [31:0] val);
        bit writes;
        m_decode(bus_b.IR_in, bus_b.RD_in, bus_b.A_in, bus_b.PC_in, writes, val);
        we = writes && bus_b.v_in && m_rout && !rst && (bus_b.AM_in != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] addr, input bit bypass);
        bit we;
        logic [31:0] val;
        m_pending(we, val);
        if (addr == 5'd0) return 32'h0;
        if (bypass && we && bus_b.AM_in == addr) return val;
        return m_regs[addr];
    endfunction

    task automatic tick();
        bit we, acc, r, st;
        logic [31:0] val;
        logic [4:0] am;
        m_pending(we, val);
        acc = bus_b.v_in && m_rout && !rst;
        r   = rst;
        st  = stall;
        am  = bus_b.AM_in;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_rout = 1'b1; m_fwd_v = 1'b0; m_fwd_rd = 5'd0; m_fwd_data = 32'h0;
            m_retire = 1'b0; m_instret = '0;
        end else begin
            m_rout   = !st;
            m_retire = acc;
            if (acc) m_instret = m_instret + 1'b1;
            m_fwd_v = we;
            if (we) begin
                m_regs[am] = val;
                m_fwd_rd   = am;
                m_fwd_data = val;
            end
        end
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ir, input logic [31:0] rd, input logic [31:0] a,
                             input logic [31:0] pc, input logic [4:0] am, input logic v);
        bus_b.IR_in = ir;
        bus_b.RD_in = rd;
        bus_b.A_in  = a;
        bus_b.PC_in = pc;
        bus_b.AM_in = am;
        bus_b.v_in  = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        set_instr(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hDEAD_BEEF;
        m_rout = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            checks++;
            if (rs1_data_b !== 32'h0) begin failures++; $display("FAIL reset_rs1 addr=%0d got=%h exp=0", a, rs1_data_b); end
            checks++;
            if (rs2_data_b !== 32'h0) begin failures++; $display("FAIL reset_rs2 addr=%0d got=%h exp=0", 31 - a, rs2_data_b); end
            checks++;
            if (rs1_data_n !== 32'h0) begin failures++; $display("FAIL reset_rs1_nobyp addr=%0d got=%h exp=0", a, rs1_data_n); end
        end
        checks++;
        if (bus_b.r_out !== 1'b1) begin failures++; $display("FAIL reset_r_out got=%b exp=1", bus_b.r_out); end
        checks++;
        if (instret !== '0) begin failures++; $display("FAIL reset_instret got=%0h exp=0", instret); end
        checks++;
        if (fwd_v !== 1'b0) begin failures++; $display("FAIL reset_fwd_v got=%b exp=0", fwd_v); end
        checks++;
        if (retire_v !== 1'b0) begin failures++; $display("FAIL reset_retire_v got=%b exp=0", retire_v); end
    endtask

    task automatic test_addi();
        set_instr(32'h0050_0093, 32'h0, 32'd5, 32'h0, 5'd1, 1'b1);
        tick();
        bus_b.v_in = 1'b0;
        rs1_addr = 5'd1;
        #1;
        checks++;
        if (rs1_data_b !== 32'd5) begin failures++; $display("FAIL addi_x1 got=%h exp=5", rs1_data_b); end
        checks++;
        if (fwd_rd !== 5'd1 || fwd_data !== 32'd5 || fwd_v !== 1'b1) begin
            failures++; $display("FAIL addi_fwd got=%0d/%h/%b exp=1/5/1", fwd_rd, fwd_data, fwd_v);
        end
        checks++;
        if (instret !== 64'd1 || retire_v !== 1'b1) begin
            failures++; $display("FAIL addi_retire got=%0d/%b exp=1/1", instret, retire_v);
        end
        tick();
        checks++;
        if (fwd_v !== 1'b0 || fwd_data !== 32'd5) begin
            failures++; $display("FAIL addi_fwd_drop got=%b/%h exp=0/5", fwd_v, fwd_data);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd3};
        logic [31:0] rd  [6] = '{32'h0000_00F0, 32'h0000_00F0, 32'h0000_8001, 32'h0000_8001, 32'h1234_5678, 32'h0000_0077};
        logic [4:0]  am  [6] = '{5'd2, 5'd3, 5'd4, 5'd9, 5'd7, 5'd10};
        logic [31:0] exp [6] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001, 32'h0000_8001, 32'h1234_5678, 32'h0};
        for (int i = 0; i < 6; i++) begin
            set_instr({17'h0, f3[i], 5'h0, 7'b0000011}, rd[i], 32'hAAAA_AAAA, 32'h40, am[i], 1'b1);
            tick();
            bus_b.v_in = 1'b0;
            rs1_addr = am[i];
            rs2_addr = am[i];
            #1;
            checks++;
            if (rs1_data_b !== exp[i]) begin failures++; $display("FAIL load_f3_%0d got=%h exp=%h", f3[i], rs1_data_b, exp[i]); end
            checks++;
            if (rs2_data_n !== exp[i]) begin failures++; $display("FAIL load_nobyp_f3_%0d got=%h exp=%h", f3[i], rs2_data_n, exp[i]); end
            checks++;
            if (retire_v !== 1'b1 || fwd_v !== m_fwd_v) begin
                failures++; $display("FAIL load_flags_f3_%0d got=%b/%b exp=1/%b", f3[i], retire_v, fwd_v, m_fwd_v);
            end
        end
    endtask

    task automatic test_bypass();
        set_instr(32'h0000_0013, 32'h0, 32'h0000_00AA, 32'h0, 5'd5, 1'b1);
        tick();
        set_instr(32'h0000_006F, 32'h0, 32'h0, 32'h0000_0100, 5'd5, 1'b1);
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data_b !== 32'h104) begin failures++; $display("FAIL bypass_same_cycle got=%h exp=104", rs1_data_b); end
        checks++;
        if (rs1_data_n !== 32'hAA) begin failures++; $display("FAIL nobypass_same_cycle got=%h exp=aa", rs1_data_n); end
        tick();
        bus_b.v_in = 1'b0;
        #1;
        checks++;
        if (rs1_data_n !== 32'h104 || rs1_data_b !== 32'h104) begin
            failures++; $display("FAIL jal_next_cycle got=%h/%h exp=104/104", rs1_data_b, rs1_data_n);
        end
    endtask

    task automatic test_nonwrites();
        logic [31:0] ir [3] = '{32'h0000_0023, 32'h0000_0063, 32'h0000_0013};
        logic [4:0]  am [3] = '{5'd0, 5'd10, 5'd0};
        logic [31:0] snap [32];
        logic [CNT_W-1:0] start;
        logic [31:0] fd;
        int pulses = 0;
        for (int i = 0; i < 32; i++) snap[i] = m_regs[i];
        start = m_instret;
        fd = m_fwd_data;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_instr(ir[i], (i == 0) ? 32'bz : 32'h5555_5555, 32'h0000_DEAD, 32'h200, am[i], 1'b1);
            tick();
            if (retire_v === 1'b1) pulses++;
            checks++;
            if (fwd_v !== 1'b0) begin failures++; $display("FAIL nonwrite_fwd_v_%0d got=%b exp=0", i, fwd_v); end
        end
        bus_b.v_in = 1'b0;
        checks++;
        if (pulses != 3) begin failures++; $display("FAIL nonwrite_pulses got=%0d exp=3", pulses); end
        checks++;
        if (instret !== start + 3) begin failures++; $display("FAIL nonwrite_instret got=%0d exp=%0d", instret, start + 3); end
        checks++;
        if (fwd_data !== fd) begin failures++; $display("FAIL nonwrite_fwd_hold got=%h exp=%h", fwd_data, fd); end
        for (int a = 1; a < 32; a++) begin
            rs1_addr = 5'(a);
            #1;
            checks++;
            if (rs1_data_b !== snap[a]) begin failures++; $display("FAIL nonwrite_reg x%0d got=%h exp=%h", a, rs1_data_b, snap[a]); end
        end
    endtask

    task automatic test_stall();
        logic [CNT_W-1:0] start;
        int pulses = 0;
        start = m_instret;
        stall = 1'b1;
        set_instr(32'h0000_0033, 32'h0, 32'h1357_9BDF, 32'h0, 5'd6, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (retire_v === 1'b1) pulses++;
            checks++;
            if (bus_b.r_out !== 1'b0) begin failures++; $display("FAIL stall_r_out_%0d got=%b exp=0", c, bus_b.r_out); end
        end
        stall = 1'b0;
        bus_b.v_in = 1'b0;
        tick();
        checks++;
        if (bus_b.r_out !== 1'b1) begin failures++; $display("FAIL stall_release_r_out got=%b exp=1", bus_b.r_out); end
        checks++;
        if (pulses != 1 || instret !== start + 1) begin
            failures++; $display("FAIL stall_single_retire got=%0d/%0d exp=1/%0d", pulses, instret, start + 1);
        end
        rs1_addr = 5'd6;
        #1;
        checks++;
        if (rs1_data_b !== 32'h1357_9BDF) begin failures++; $display("FAIL stall_x6 got=%h exp=13579bdf", rs1_data_b); end
    endtask

    task automatic test_rst_stall();
        stall = 1'b1;
        bus_b.v_in = 1'b0;
        tick();
        set_instr(32'h0000_0033, 32'h0, 32'h55, 32'h0, 5'd8, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        bus_b.v_in = 1'b0;
        checks++;
        if (bus_b.r_out !== 1'b1) begin failures++; $display("FAIL rst_stall_r_out got=%b exp=1", bus_b.r_out); end
        checks++;
        if (instret !== '0 || retire_v !== 1'b0 || fwd_v !== 1'b0) begin
            failures++; $display("FAIL rst_stall_retire got=%0d/%b/%b exp=0/0/0", instret, retire_v, fwd_v);
        end
        rs1_addr = 5'd8;
        rs2_addr = 5'd6;
        #1;
        checks++;
        if (rs1_data_b !== 32'h0 || rs2_data_b !== 32'h0) begin
            failures++; $display("FAIL rst_stall_regs got=%h/%h exp=0/0", rs1_data_b, rs2_data_b);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [12] = '{7'h03, 7'h03, 7'h03, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23, 7'h63, 7'h0B};
        logic [31:0] ir, rd, e1, e2, e3, e4;
        for (int n = 0; n < 500; n++) begin
            ir = $urandom;
            ir[6:0] = ops[$urandom_range(0, 11)];
            rd = (ir[6:0] != 7'h03 && $urandom_range(0, 1) == 1) ? 32'bz : $urandom;
            set_instr(ir, rd, $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 99) == 0);
            rs1_addr = ($urandom_range(0, 2) == 0) ? bus_b.AM_in : 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            #1;
            e1 = m_read(rs1_addr, 1'b1);
            e2 = m_read(rs2_addr, 1'b1);
            e3 = m_read(rs1_addr, 1'b0);
            e4 = m_read(rs2_addr, 1'b0);
            checks++;
            if (rs1_data_b !== e1 || rs2_data_b !== e2) begin
                failures++; $display("FAIL rand_read_byp n=%0d got=%h/%h exp=%h/%h", n, rs1_data_b, rs2_data_b, e1, e2);
            end
            checks++;
            if (rs1_data_n !== e3 || rs2_data_n !== e4) begin
                failures++; $display("FAIL rand_read_nobyp n=%0d got=%h/%h exp=%h/%h", n, rs1_data_n, rs2_data_n, e3, e4);
            end
            tick();
            checks++;
            if (bus_b.r_out !== m_rout || bus_n.r_out !== m_rout) begin
                failures++; $display("FAIL rand_r_out n=%0d got=%b/%b exp=%b", n, bus_b.r_out, bus_n.r_out, m_rout);
            end
            checks++;
            if (retire_v !== m_retire || instret !== m_instret || retire_v_n !== m_retire || instret_n !== m_instret) begin
                failures++; $display("FAIL rand_retire n=%0d got=%b/%0d exp=%b/%0d", n, retire_v, instret, m_retire, m_instret);
            end
            checks++;
            if (fwd_v !== m_fwd_v || fwd_rd !== m_fwd_rd || fwd_data !== m_fwd_data ||
                fwd_v_n !== m_fwd_v || fwd_rd_n !== m_fwd_rd || fwd_data_n !== m_fwd_data) begin
                failures++; $display("FAIL rand_fwd n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, fwd_v, fwd_rd, fwd_data, m_fwd_v, m_fwd_rd, m_fwd_data);
            end
        end
        rst = 1'b0;
        stall = 1'b0;
        bus_b.v_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_loads();
        test_bypass();
        test_nonwrites();
        test_stall();
        test_rst_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Final pipeline stage; sole consumer of the memory stage's outputs.
- Takes each retiring instruction's IR, load data, ALU result, PC and destination address.
- Builds the architectural write-back value (load sign/zero extension, ALU or link value) and writes the 32x32 integer register file.
- Provides the two combinational register read ports for decode, a registered forwarding tap for execute, and a retired-instruction counter.

Parameters:
- CNT_W, 64, width of the retired-instruction counter.
- BYPASS, 1, when 1 a read port addressing the register being written this cycle returns the new data (write-through); when 0 it returns the old contents.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- IR_in  input  32  instruction from the memory stage.
- RD_in  input  32  raw load data (byte/half zero-filled in the low bits).
- A_in  input  32  ALU result / effective address.
- PC_in  input  32  address of the instruction.
- AM_in  input  5  destination register; 0 means no write.
- v_in  input  1  memory-stage valid.
- stall  input  1  hold request from the hazard unit.
- r_out  output  1  ready to the memory stage.
- rs1_addr  input  5  decode read port 1 address.
- rs2_addr  input  5  decode read port 2 address.
- rs1_data  output  32  read port 1 data, combinational.
- rs2_data  output  32  read port 2 data, combinational.
- fwd_rd  output  5  destination of the last committed write.
- fwd_data  output  32  value of the last committed write.
- fwd_v  output  1  fwd_rd/fwd_data valid.
- retire_v  output  1  one-cycle pulse per retired instruction.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Accept: an instruction is accepted on a rising clk edge with v_in & r_out & ~rst. Registers are written on that same edge (zero extra latency).
- r_out: registered. Reset value 1. Each edge: r_out <= ~stall.
- Value select, by IR_in[6:0]:
  - 0000011 (load), by IR_in[14:12]:
    - 0: sign-extend RD_in[7:0]
    - 4: zero-extend RD_in[7:0]
    - 1: sign-extend RD_in[15:0]
    - 5: zero-extend RD_in[15:0]
    - 2: RD_in
    - any other funct3: no write; still counts as retired.
  - 0110011, 0010011, 0110111, 0010111: A_in.
  - 1101111, 1100111: PC_in + 4, modulo 2^32.
  - 0100011, 1100011, or any other opcode: no write.
- Write enable: accept & selecting opcode & AM_in != 0.
- x0: reads as 0 always; a write to x0 is never performed.
- Read ports:
  - rsN_data = 0 if rsN_addr == 0.
  - Otherwise, if BYPASS and a write is enabled this cycle to rsN_addr: the write value.
  - Otherwise: the stored register.
- Forwarding tap, updated every edge:
  - On a write: fwd_v <= 1, fwd_rd <= AM_in, fwd_data <= value.
  - Otherwise: fwd_v <= 0; fwd_rd and fwd_data hold.
- Retire:
  - retire_v <= accept (includes non-writing instructions).
  - instret increments by 1 per accept and wraps modulo 2^CNT_W.
- stall asserted with v_in:
  - The instruction is accepted only if r_out was already 1 that cycle.
  - Subsequent cycles reject until r_out returns to 1.
  - The memory stage holds its outputs meanwhile; no double write, no double count.
- Reset (rst high at an edge):
  - All 31 registers <= 0, r_out <= 1, fwd_v <= 0, fwd_rd <= 0, fwd_data <= 0, retire_v <= 0, instret <= 0.
  - Any v_in in the same cycle is discarded: no write, no count.
  - Reset asserted mid-stall also forces r_out to 1.
- No X propagation: a high-Z RD_in on a non-load must not reach any register.

Test Plan:
- Reset, then read every address -> all rsN_data 0, r_out 1, instret 0, fwd_v 0.
- Accept ADDI (IR 0x00500093, AM 1, A 5) -> x1 = 5, fwd_rd 1, fwd_data 5, fwd_v 1 for one cycle, instret 1.
- Loads with RD 0x000000F0:
  - LB (funct3 0), AM 2 -> x2 = 0xFFFFFFF0.
  - LBU, AM 3 -> x3 = 0x000000F0.
  - LH with RD 0x00008001 -> 0xFFFF8001.
  - LW with RD 0x12345678 -> 0x12345678.
- Write-through: accept JAL (AM 5, PC 0x100) while rs1_addr = 5:
  - BYPASS=1 -> rs1_data 0x104 in the same cycle.
  - BYPASS=0 -> old value that cycle, 0x104 the next.
- Non-writes: SW (AM 0, RD Z), BEQ, and ADDI with AM 0 -> no register changes, fwd_v stays 0, instret +3, retire_v pulses 3 times.
- Handshake: raise stall for 3 cycles with v_in held on an ADD -> exactly one write and one increment. Assert rst during the stall with v_in high -> nothing retired, r_out 1 after reset.
